// File: rtl/pipelined_shifter_if.sv
// Handshake bundle for pipelined_shifter.
//   master side (producer/consumer around the shifter): drives in_valid, in_op,
//     in_shamt, in_data, in_tag, out_ready; observes in_ready and the out_* result.
//   slave side (the shifter): the mirror image.
// SHAMT_WIDTH is derived from DATA_WIDTH and is not meant to be overridden.
interface pipelined_shifter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 5
);
   localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

   logic                   in_valid;
   logic                   in_ready;
   logic [2:0]             in_op;
   logic [SHAMT_WIDTH-1:0] in_shamt;
   logic [DATA_WIDTH-1:0]  in_data;
   logic [TAG_WIDTH-1:0]   in_tag;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_WIDTH-1:0]  out_data;
   logic [TAG_WIDTH-1:0]   out_tag;
   logic                   out_err;

   modport master (
      output in_valid, in_op, in_shamt, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_err
   );

   modport slave (
      input  in_valid, in_op, in_shamt, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_err
   );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA/ROL/ROR shifter with valid/ready on both sides.
// The shift amount is split across STAGES register stages; shamt bit j is
// applied in stage (j*STAGES)/SHAMT_WIDTH, stage 0 being combinational from
// the inputs. An opaque tag travels with each operation.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous, active-high reset
//   flush - synchronous; drops every in-flight operation
//   bus   - pipelined_shifter_if.slave: in_* request side, out_* result side
// Op codes: 000 SLL, 010 SRL, 011 SRA, 100 ROL, 110 ROR; anything else passes
// the operand through unshifted with out_err set.
module pipelined_shifter #(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = 2,
   parameter int TAG_WIDTH  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   pipelined_shifter_if.slave bus
);
   localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b010;
   localparam logic [2:0] OP_SRA = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b110;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]  data;
      logic [2:0]             op;
      logic [SHAMT_WIDTH-1:0] shamt;
      logic [TAG_WIDTH-1:0]   tag;
      logic                   err;
      logic                   fill;
   } stage_t;

   logic [STAGES-1:0] valid_q;
   stage_t            stage_q [STAGES];
   stage_t            stage_d [STAGES];
   logic [STAGES-1:0] adv;
   stage_t            entry;
   logic              illegal;

   function automatic logic owns_bit(int j, int k);
      return ((j * STAGES) / SHAMT_WIDTH) == k;
   endfunction

   // Apply the shamt bits owned by stage k. Each owned set bit j contributes a
   // shift of 2^j; rotates compose the same way since they add modulo width.
   function automatic stage_t apply_stage(stage_t s, int k);
      stage_t                r;
      logic [DATA_WIDTH-1:0] d;
      int                    amt;
      r = s;
      d = s.data;
      for (int j = 0; j < SHAMT_WIDTH; j++) begin
         amt = 1 << j;
         if (owns_bit(j, k) && s.shamt[j]) begin
            case (s.op)
               OP_SLL:  d = d << amt;
               OP_SRL:  d = d >> amt;
               OP_SRA:  d = (d >> amt) | (s.fill ? ~({DATA_WIDTH{1'b1}} >> amt) : '0);
               OP_ROL:  d = (d << amt) | (d >> (DATA_WIDTH - amt));
               OP_ROR:  d = (d >> amt) | (d << (DATA_WIDTH - amt));
               default: d = d;
            endcase
         end
      end
      r.data = d;
      return r;
   endfunction

   always_comb begin
      case (bus.in_op)
         OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: illegal = 1'b0;
         default:                                illegal = 1'b1;
      endcase
   end

   // Illegal ops get a zero shift amount so they pass through untouched.
   // The SRA fill bit is captured here so later stages never need the
   // original operand.
   always_comb begin
      entry       = '0;
      entry.data  = bus.in_data;
      entry.op    = bus.in_op;
      entry.shamt = illegal ? '0 : bus.in_shamt;
      entry.tag   = bus.in_tag;
      entry.err   = illegal;
      entry.fill  = bus.in_data[DATA_WIDTH-1];
   end

   always_comb begin
      stage_d[0] = apply_stage(entry, 0);
      for (int k = 1; k < STAGES; k++) begin
         stage_d[k] = apply_stage(stage_q[k-1], k);
      end
   end

   // Stage k may load when any stage from k downward is empty or the result
   // is being taken. Written as a flat OR so there is no bit-to-bit loop.
   always_comb begin
      adv = '0;
      for (int k = 0; k < STAGES; k++) begin
         logic a;
         a = bus.out_ready;
         for (int j = k; j < STAGES; j++) begin
            a = a | !valid_q[j];
         end
         adv[k] = a;
      end
   end

   assign bus.in_ready = adv[0] && !flush && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else if (flush) begin
         valid_q <= '0;
      end else begin
         if (adv[0]) begin
            valid_q[0] <= bus.in_valid;
            if (bus.in_valid) begin
               stage_q[0] <= stage_d[0];
            end
         end
         for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
               valid_q[k] <= valid_q[k-1];
               if (valid_q[k-1]) begin
                  stage_q[k] <= stage_d[k];
               end
            end
         end
      end
   end

   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.out_data  = stage_q[STAGES-1].data;
   assign bus.out_tag   = stage_q[STAGES-1].tag;
   assign bus.out_err   = stage_q[STAGES-1].err;
endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: a DATA_WIDTH=32/STAGES=2 instance for directed
// vectors and multi-cycle corner cases, plus 32/1, 32/5 and 64/3 instances
// swept over all ops with a latency check.
module tb_pipelined_shifter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic aux_flush = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_vec = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Independent reference: whole-amount shifts on a masked 64-bit word.
   function automatic logic [64:0] ref_shift(logic [63:0] din, logic [2:0] op, int sh, int w);
      logic [63:0] mask, d, r;
      logic        e, sgn;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      d    = din & mask;
      sgn  = d[w-1];
      e    = 1'b0;
      r    = d;
      case (op)
         3'b000: r = d << sh;
         3'b010: r = d >> sh;
         3'b011: begin
            r = d >> sh;
            if (sgn) r = r | (mask & ~(mask >> sh));
         end
         3'b100: if (sh != 0) r = (d << sh) | (d >> (w - sh));
         3'b110: if (sh != 0) r = (d >> sh) | (d << (w - sh));
         default: e = 1'b1;
      endcase
      return {e, r & mask};
   endfunction

   // ---------------- main DUT ----------------
   pipelined_shifter_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) m ();
   pipelined_shifter #(.DATA_WIDTH(32), .STAGES(2), .TAG_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(m)
   );

   // ---------------- sweep DUTs ----------------
   logic        aux_on = 1'b0;
   logic        aux_valid = 1'b0;
   logic [2:0]  aux_op = 3'b000;
   logic [5:0]  aux_shamt = 6'd0;
   logic [63:0] aux_data = 64'd0;
   logic [4:0]  aux_tag = 5'd0;

   pipelined_shifter_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) a1 ();
   pipelined_shifter_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) a5 ();
   pipelined_shifter_if #(.DATA_WIDTH(64), .TAG_WIDTH(5)) a6 ();
   pipelined_shifter #(.DATA_WIDTH(32), .STAGES(1), .TAG_WIDTH(5)) u_s1 (
      .clk(clk), .rst(rst), .flush(aux_flush), .bus(a1));
   pipelined_shifter #(.DATA_WIDTH(32), .STAGES(5), .TAG_WIDTH(5)) u_s5 (
      .clk(clk), .rst(rst), .flush(aux_flush), .bus(a5));
   pipelined_shifter #(.DATA_WIDTH(64), .STAGES(3), .TAG_WIDTH(5)) u_w64 (
      .clk(clk), .rst(rst), .flush(aux_flush), .bus(a6));

   assign a1.in_valid = aux_valid;  assign a1.in_op = aux_op;  assign a1.in_shamt = aux_shamt[4:0];
   assign a1.in_data = aux_data[31:0];  assign a1.in_tag = aux_tag;  assign a1.out_ready = 1'b1;
   assign a5.in_valid = aux_valid;  assign a5.in_op = aux_op;  assign a5.in_shamt = aux_shamt[4:0];
   assign a5.in_data = aux_data[31:0];  assign a5.in_tag = aux_tag;  assign a5.out_ready = 1'b1;
   assign a6.in_valid = aux_valid;  assign a6.in_op = aux_op;  assign a6.in_shamt = aux_shamt;
   assign a6.in_data = aux_data;  assign a6.in_tag = aux_tag;  assign a6.out_ready = 1'b1;

   logic [2:0]  ov, oe, ir;
   logic [63:0] od [3];
   logic [4:0]  ot [3];
   assign ov[0] = a1.out_valid;  assign oe[0] = a1.out_err;  assign ir[0] = a1.in_ready;
   assign od[0] = {32'd0, a1.out_data};  assign ot[0] = a1.out_tag;
   assign ov[1] = a5.out_valid;  assign oe[1] = a5.out_err;  assign ir[1] = a5.in_ready;
   assign od[1] = {32'd0, a5.out_data};  assign ot[1] = a5.out_tag;
   assign ov[2] = a6.out_valid;  assign oe[2] = a6.out_err;  assign ir[2] = a6.in_ready;
   assign od[2] = a6.out_data;  assign ot[2] = a6.out_tag;

   typedef struct {
      int          c;
      logic [2:0]  op;
      logic [5:0]  sh;
      logic [63:0] d;
      logic [4:0]  tag;
   } iss_t;
   iss_t iss [64];
   int   n_iss = 0;
   int   rp [3] = '{0, 0, 0};
   int   as_stages [3] = '{1, 5, 3};
   int   aw_width  [3] = '{32, 32, 64};
   logic        aux_ev;
   logic [64:0] aux_r;

   always @(negedge clk) begin
      if (aux_on) begin
         for (int d = 0; d < 3; d++) begin
            aux_ev = (rp[d] < n_iss) && (iss[rp[d]].c + as_stages[d] == cyc);
            chk($sformatf("sweep_valid_%0d", d), ov[d], aux_ev);
            if (aux_ev && ov[d]) begin
               aux_r = ref_shift(iss[rp[d]].d, iss[rp[d]].op,
                                 int'(iss[rp[d]].sh) % aw_width[d], aw_width[d]);
               chk($sformatf("sweep_data_%0d", d), od[d], aux_r[63:0]);
               chk($sformatf("sweep_err_%0d", d), oe[d], aux_r[64]);
               chk($sformatf("sweep_tag_%0d", d), ot[d], iss[rp[d]].tag);
               rp[d]++;
            end
         end
         if (aux_valid) begin
            for (int d = 0; d < 3; d++) chk($sformatf("sweep_in_ready_%0d", d), ir[d], 1'b1);
            iss[n_iss] = '{cyc, aux_op, aux_shamt, aux_data, aux_tag};
            n_iss++;
         end
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [2:0]  op;
      logic [4:0]  sh;
      logic [31:0] d;
      logic [4:0]  tag;
      logic [31:0] exp;
      logic        err;
   } vec_t;
   vec_t vt [16];

   typedef struct packed {
      logic [31:0] d;
      logic [4:0]  t;
      logic        e;
   } exp_t;
   exp_t sq [$];

   logic [2:0] opsel [6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b001};

   task automatic drive_idle();
      m.in_valid = 1'b0;  m.in_op = 3'b000;  m.in_shamt = 5'd0;
      m.in_data = 32'd0;  m.in_tag = 5'd0;
   endtask

   task automatic drive_op(input logic [2:0] op, input logic [4:0] sh,
                           input logic [31:0] d, input logic [4:0] tag);
      m.in_valid = 1'b1;  m.in_op = op;  m.in_shamt = sh;  m.in_data = d;  m.in_tag = tag;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  sop [8];
      logic [4:0]  ssh [8];
      logic [31:0] sdat [8];
      logic [64:0] r;
      exp_t        e;
      int          i, got, t0;
      logic        stall, seen;
      logic [31:0] pd;
      logic [4:0]  pt;

      vt[0]  = '{3'b000, 5'd31, 32'h0000_0001, 5'h15, 32'h8000_0000, 1'b0};
      vt[1]  = '{3'b011, 5'd4,  32'h8000_0010, 5'h01, 32'hF800_0001, 1'b0};
      vt[2]  = '{3'b010, 5'd4,  32'h8000_0010, 5'h02, 32'h0800_0001, 1'b0};
      vt[3]  = '{3'b011, 5'd31, 32'h7FFF_FFFF, 5'h03, 32'h0000_0000, 1'b0};
      vt[4]  = '{3'b110, 5'd4,  32'h0000_00F1, 5'h04, 32'h1000_000F, 1'b0};
      vt[5]  = '{3'b100, 5'd1,  32'h8000_0001, 5'h05, 32'h0000_0003, 1'b0};
      vt[6]  = '{3'b001, 5'd7,  32'h1234_5678, 5'h06, 32'h1234_5678, 1'b1};
      vt[7]  = '{3'b011, 5'd31, 32'h8000_0000, 5'h07, 32'hFFFF_FFFF, 1'b0};
      vt[8]  = '{3'b000, 5'd0,  32'hDEAD_BEEF, 5'h08, 32'hDEAD_BEEF, 1'b0};
      vt[9]  = '{3'b110, 5'd0,  32'hDEAD_BEEF, 5'h09, 32'hDEAD_BEEF, 1'b0};
      vt[10] = '{3'b100, 5'd8,  32'h1234_5678, 5'h0A, 32'h3456_7812, 1'b0};
      vt[11] = '{3'b010, 5'd1,  32'hFFFF_FFFF, 5'h0B, 32'h7FFF_FFFF, 1'b0};
      vt[12] = '{3'b111, 5'd3,  32'hABCD_EF01, 5'h0C, 32'hABCD_EF01, 1'b1};
      vt[13] = '{3'b110, 5'd31, 32'h1234_5678, 5'h0D, 32'h2468_ACF0, 1'b0};
      vt[14] = '{3'b011, 5'd0,  32'h8765_4321, 5'h0E, 32'h8765_4321, 1'b0};
      vt[15] = '{3'b000, 5'd4,  32'h1234_5678, 5'h1F, 32'h2345_6780, 1'b0};

      drive_idle();
      m.out_ready = 1'b1;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", m.out_valid, 1'b0);
      chk("rst_out_data", m.out_data, 32'd0);
      chk("rst_out_tag", m.out_tag, 5'd0);
      chk("rst_out_err", m.out_err, 1'b0);
      chk("rst_in_ready", m.in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", m.in_ready, 1'b1);
      step();

      // table: one op at a time, result one edge after the accept edge
      for (int k = 0; k < 16; k++) begin
         drive_op(vt[k].op, vt[k].sh, vt[k].d, vt[k].tag);
         chk($sformatf("tbl%0d_in_ready", k), m.in_ready, 1'b1);
         step();
         drive_idle();
         chk($sformatf("tbl%0d_early_valid", k), m.out_valid, 1'b0);
         step();
         chk($sformatf("tbl%0d_valid", k), m.out_valid, 1'b1);
         chk($sformatf("tbl%0d_data", k), m.out_data, vt[k].exp);
         chk($sformatf("tbl%0d_tag", k), m.out_tag, vt[k].tag);
         chk($sformatf("tbl%0d_err", k), m.out_err, vt[k].err);
      end
      step();

      // back-to-back stream with random out_ready
      for (int k = 0; k < 8; k++) begin
         sop[k]  = opsel[$urandom_range(0, 5)];
         ssh[k]  = 5'($urandom_range(0, 31));
         sdat[k] = $urandom;
      end
      i = 0;  got = 0;  stall = 1'b0;  pd = 32'd0;  pt = 5'd0;  t0 = cyc;
      while (got < 8 && (cyc - t0) < 300) begin
         m.out_ready = 1'($urandom_range(0, 1));
         if (i < 8) drive_op(sop[i], ssh[i], sdat[i], 5'(i + 16));
         else drive_idle();
         @(negedge clk);
         if (stall) begin
            chk("stall_data", m.out_data, pd);
            chk("stall_tag", m.out_tag, pt);
         end
         if (m.out_valid && m.out_ready) begin
            if (sq.size() == 0) begin
               chk("stream_unexpected_result", 1'b1, 1'b0);
            end else begin
               e = sq.pop_front();
               chk("stream_data", m.out_data, e.d);
               chk("stream_tag", m.out_tag, e.t);
               chk("stream_err", m.out_err, e.e);
            end
            got++;
         end
         if (m.in_valid && m.in_ready) begin
            r = ref_shift({32'd0, sdat[i]}, sop[i], int'(ssh[i]), 32);
            sq.push_back('{r[31:0], 5'(i + 16), r[64]});
            i++;
         end
         stall = m.out_valid && !m.out_ready;
         pd = m.out_data;
         pt = m.out_tag;
         step();
      end
      chk("stream_count", got, 8);
      drive_idle();
      m.out_ready = 1'b1;
      step();

      // capacity: two ops fill the pipe with out_ready low
      m.out_ready = 1'b0;
      drive_op(3'b000, 5'd1, 32'h0000_0001, 5'd1);
      chk("cap_in_ready0", m.in_ready, 1'b1);
      step();
      drive_op(3'b010, 5'd3, 32'h0000_0080, 5'd2);
      chk("cap_in_ready1", m.in_ready, 1'b1);
      step();
      drive_op(3'b100, 5'd4, 32'hF000_0000, 5'd3);
      chk("cap_full_in_ready", m.in_ready, 1'b0);
      chk("cap_full_valid", m.out_valid, 1'b1);
      chk("cap_full_data", m.out_data, 32'h0000_0002);
      repeat (3) step();
      chk("cap_hold_in_ready", m.in_ready, 1'b0);
      chk("cap_hold_data", m.out_data, 32'h0000_0002);
      chk("cap_hold_tag", m.out_tag, 5'd1);
      m.out_ready = 1'b1;
      #1;
      chk("cap_ready_comb", m.in_ready, 1'b1);
      step();
      drive_idle();
      chk("cap_b_data", m.out_data, 32'h0000_0010);
      chk("cap_b_tag", m.out_tag, 5'd2);
      step();
      chk("cap_c_valid", m.out_valid, 1'b1);
      chk("cap_c_data", m.out_data, 32'h0000_000F);
      chk("cap_c_tag", m.out_tag, 5'd3);
      step();
      chk("cap_drained", m.out_valid, 1'b0);

      // flush with two ops in flight
      m.out_ready = 1'b0;
      drive_op(3'b000, 5'd2, 32'h0000_0003, 5'd4);
      step();
      drive_op(3'b000, 5'd3, 32'h0000_0003, 5'd5);
      step();
      flush = 1'b1;
      drive_op(3'b000, 5'd4, 32'h0000_0003, 5'd6);
      #1;
      chk("flush_in_ready", m.in_ready, 1'b0);
      step();
      flush = 1'b0;
      drive_idle();
      m.out_ready = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         seen = seen | m.out_valid;
         step();
      end
      chk("flush_no_valid", seen, 1'b0);

      // asynchronous reset mid-stream
      m.out_ready = 1'b0;
      drive_op(3'b011, 5'd1, 32'h8000_0000, 5'd7);
      step();
      drive_op(3'b011, 5'd2, 32'h8000_0000, 5'd8);
      step();
      drive_idle();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", m.out_valid, 1'b0);
      chk("arst_in_ready", m.in_ready, 1'b0);
      chk("arst_out_data", m.out_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      m.out_ready = 1'b1;
      step();
      drive_op(3'b011, 5'd1, 32'h8000_0000, 5'd9);
      chk("arst_next_in_ready", m.in_ready, 1'b1);
      step();
      drive_idle();
      step();
      chk("arst_next_valid", m.out_valid, 1'b1);
      chk("arst_next_data", m.out_data, 32'hC000_0000);
      chk("arst_next_tag", m.out_tag, 5'd9);

      // sweep over all ops on STAGES=1, STAGES=5 and DATA_WIDTH=64
      aux_on = 1'b1;
      for (int o = 0; o < 6; o++) begin
         for (int s = 0; s < 4; s++) begin
            aux_valid = 1'b1;
            aux_op    = opsel[o];
            aux_shamt = (s == 0) ? 6'd0 : (s == 1) ? 6'd1 : (s == 2) ? 6'd63 : 6'($urandom_range(0, 63));
            aux_data  = {$urandom, $urandom};
            aux_tag   = n_iss[4:0];
            step();
         end
      end
      aux_valid = 1'b0;
      repeat (8) step();
      for (int d = 0; d < 3; d++) chk($sformatf("sweep_drain_%0d", d), rp[d], n_iss);
      aux_on = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined successor to the single-cycle combinational shifter in the simple core's execute path. Performs SLL/SRL/SRA plus ROL/ROR on a DATA_WIDTH operand, splitting the shift amount across STAGES register stages. Valid/ready handshakes sit on both sides and an opaque tag travels with each operation, so the block can serve an out-of-order or multi-cycle ALU slot at one operation per clock.

## Interface
- DATA_WIDTH, 32: operand width; power of two, 8..64.
- SHAMT_WIDTH, $clog2(DATA_WIDTH): derived, not overridden.
- STAGES, 2: pipeline register stages; 1..SHAMT_WIDTH.
- TAG_WIDTH, 5: width of the pass-through tag (e.g. rd index).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; drops all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  block accepts the input this cycle.
- in_op  in  3  000 SLL, 010 SRL, 011 SRA, 100 ROL, 110 ROR; others illegal.
- in_shamt  in  SHAMT_WIDTH  shift amount, unsigned.
- in_data  in  DATA_WIDTH  operand.
- in_tag  in  TAG_WIDTH  carried unchanged to out_tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_WIDTH  result.
- out_tag  out  TAG_WIDTH  tag of the result.
- out_err  out  1  operation had an illegal op code.

## Operation
- Shift amount bit j is applied in stage floor(j*STAGES/SHAMT_WIDTH). Stage 0 applies the low bits and is combinational from the inputs into stage-0 registers. Each stage shifts by 2^j for every set bit j it owns.
- Each stage register holds valid, partial data, remaining op, remaining shamt bits, tag and err. The last stage register drives the out_* ports directly.
- SLL: zero fill at LSB. SRL: zero fill at MSB. SRA: fill with the original in_data[DATA_WIDTH-1], latched at stage 0 and carried. ROL/ROR: bits wrap, so the result equals a rotate by in_shamt mod DATA_WIDTH.
- Illegal op: data passes through unshifted and out_err=1 with that result. It still occupies a slot and completes normally.
- Advance rule, per stage k: the stage loads from upstream when it is empty or when its downstream consumes it this cycle. The last stage's downstream consumes on out_valid && out_ready. The result is fully pipelined; there are no bubbles under continuous flow.
- in_ready = !valid[0] || stage 0 advances this cycle. in_ready is combinational from out_ready through the chain, with no combinational path from in_valid.
- Transfer occurs on valid && ready at each side. Operations are never dropped, duplicated or reordered except by flush or rst.
- flush: all valid bits clear on the next edge. An input presented in the same cycle is not accepted, and in_ready=0 while flush=1.

## Timing
- Reset (async assert, held while rst=1): all valid bits 0; out_valid=0, out_data=0, out_tag=0, out_err=0; in_ready=0 while rst=1. in_ready=1 in the first cycle after deassertion.
- Latency: an input accepted at edge N is visible on out_* after edge N+STAGES-1, so out_valid is high in cycle N+STAGES-1 relative to the accept edge. With STAGES=1, the result appears the cycle after acceptance.
- Throughput is 1 op/cycle with out_ready held high.
- Capacity is STAGES operations. With out_ready=0, the pipeline fills and in_ready drops once all stages are valid.
- out_data, out_tag and out_err stay stable while out_valid && !out_ready.
- Reset or flush in mid-operation loses all in-flight ops, and no partial result is ever presented.
- shamt=0 returns in_data for every legal op.

## Test plan
- DATA_WIDTH=32, STAGES=2: SLL 0x0000_0001 by 31 -> 0x8000_0000, tag echoed, valid exactly 1 cycle after accept.
- SRA 0x8000_0010 by 4 -> 0xF800_0001; SRL same operand -> 0x0800_0001; SRA 0x7FFF_FFFF by 31 -> 0x0000_0000.
- ROR 0x0000_00F1 by 4 -> 0x1000_000F; ROL 0x8000_0001 by 1 -> 0x0000_0003; illegal op 001 on 0x1234_5678 -> 0x1234_5678 with out_err=1.
- Back-to-back 8 ops with random out_ready: results come in order and match a reference model. out_* is stable while stalled, and in_ready=0 after 2 ops are buffered with out_ready=0.
- Assert flush with 2 ops in flight -> no out_valid follows. Assert rst asynchronously mid-stream -> out_valid=0 immediately, and the next op after release completes correctly.
- Sweep STAGES=1 and STAGES=5, and DATA_WIDTH=64 with shamt 63, over all ops -> correct results and latency equal to STAGES.
